fetch_pc_stage: RTL and testbench

Instruction-fetch stage of the pipelined processor: owns the 12-bit program counter, drives the instruction-memory address, selects next-PC (sequential PC+1, redirect target, or hold) and loads the IF/ID pipeline register. It sits between the branch/jump resolution logic in execute, which drives redirects, and decode, which consumes the IF/ID register.

---
 rtl/fetch_pc_stage_pkg.sv | 12 +
 rtl/fetch_pc_stage_counter.sv | 9 +
 rtl/fetch_pc_stage.sv | 80 ++++++++
 tb/tb_fetch_pc_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_stage_pkg.sv
// fetch_pc_stage_pkg: shared processor constants and fetch-state encoding
package fetch_pc_stage_pkg;
  localparam int PC_W = 12;
  localparam int INSN_W = 32;
  localparam logic [PC_W-1:0] RESET_PC = 12'h000;
  localparam logic [INSN_W-1:0] NOP = 32'h0;
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_pc_stage_counter.sv
// bit12_counter: unsigned wrap-around incrementer for the program counter
module bit12_counter
  import fetch_pc_stage_pkg::*;
(
  input  logic [PC_W-1:0] in1,
  output logic [PC_W-1:0] out1
);
  assign out1 = in1 + PC_W'(1);
endmodule

// File: rtl/fetch_pc_stage.sv
// fetch_pc_stage: program counter, next-PC selection and IF/ID pipeline register
module fetch_pc_stage
  import fetch_pc_stage_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_target,
  input  logic              halt,
  input  logic [INSN_W-1:0] imem_q,
  output logic [PC_W-1:0]   imem_addr,
  output logic [PC_W-1:0]   ifid_pc,
  output logic [PC_W-1:0]   ifid_pc_plus1,
  output logic [INSN_W-1:0] ifid_insn,
  output logic              ifid_valid,
  output logic              halted
);
  fetch_state_e state, state_nx;
  logic [PC_W-1:0] pc_q, pc_inc, pc_nx, ifid_pc_nx, ifid_pc_plus1_nx;
  logic [INSN_W-1:0] ifid_insn_nx;
  logic ifid_valid_nx, halted_nx;
  bit12_counter u_inc (
    .in1 (pc_q),
    .out1(pc_inc)
  );
  assign imem_addr = pc_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= BOOT;
      pc_q <= RESET_PC;
      ifid_pc <= '0;
      ifid_pc_plus1 <= '0;
      ifid_insn <= NOP;
      ifid_valid <= 1'b0;
      halted <= 1'b0;
    end else begin
      state <= state_nx;
      pc_q <= pc_nx;
      ifid_pc <= ifid_pc_nx;
      ifid_pc_plus1 <= ifid_pc_plus1_nx;
      ifid_insn <= ifid_insn_nx;
      ifid_valid <= ifid_valid_nx;
      halted <= halted_nx;
    end
  end
  // Redirect beats halt beats stall; BOOT and HALT ignore every input.
  always_comb begin
    state_nx = state;
    pc_nx = pc_q;
    ifid_pc_nx = ifid_pc;
    ifid_pc_plus1_nx = ifid_pc_plus1;
    ifid_insn_nx = ifid_insn;
    ifid_valid_nx = ifid_valid;
    halted_nx = halted;
    unique case (state)
      BOOT: state_nx = RUN;
      RUN: begin
        if (redirect) begin
          pc_nx = redirect_target;
          ifid_insn_nx = NOP;
          ifid_valid_nx = 1'b0;
        end else if (halt) begin
          state_nx = HALT;
          ifid_insn_nx = NOP;
          ifid_valid_nx = 1'b0;
          halted_nx = 1'b1;
        end else if (!stall) begin
          pc_nx = pc_inc;
          ifid_pc_nx = pc_q;
          ifid_pc_plus1_nx = pc_inc;
          ifid_insn_nx = imem_q;
          ifid_valid_nx = 1'b1;
        end
      end
      HALT: ifid_valid_nx = 1'b0;
      default: state_nx = BOOT;
    endcase
  end
endmodule

// File: tb/tb_fetch_pc_stage.sv
// tb_fetch_pc_stage: randomized and directed checks against a behavioural fetch model
module tb_fetch_pc_stage;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic stall = 1'b0, redirect = 1'b0, halt = 1'b0;
  logic [11:0] redirect_target = '0;
  logic [31:0] imem_q;
  logic [11:0] imem_addr, ifid_pc, ifid_pc_plus1;
  logic [31:0] ifid_insn;
  logic ifid_valid, halted;
  int n_checks = 0, n_fail = 0;
  int m_mode, m_pc, m_ipc, m_ipc1, m_valid;
  logic [31:0] m_insn;

  fetch_pc_stage dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .halt(halt), .imem_q(imem_q),
    .imem_addr(imem_addr), .ifid_pc(ifid_pc), .ifid_pc_plus1(ifid_pc_plus1),
    .ifid_insn(ifid_insn), .ifid_valid(ifid_valid), .halted(halted)
  );

  always #5 clock = ~clock;
  assign imem_q = 32'hA000_0000 + {20'd0, imem_addr};

  function automatic logic [69:0] obs();
    return {imem_addr, ifid_pc, ifid_pc_plus1, ifid_insn, ifid_valid, halted};
  endfunction

  function automatic logic [69:0] expv();
    return {12'(m_pc), 12'(m_ipc), 12'(m_ipc1), m_insn, m_valid != 0, m_mode == 2};
  endfunction

  // Model modes: 0 waiting one settle cycle, 1 fetching, 2 stopped for good.
  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_ipc = 0; m_ipc1 = 0; m_insn = 0; m_valid = 0;
  endtask

  task automatic step(input logic s, input logic r, input logic [11:0] t, input logic h);
    stall = s; redirect = r; redirect_target = t; halt = h;
    @(posedge clock);
    if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1) begin
      if (r) begin m_pc = int'(t); m_valid = 0; m_insn = 0; end
      else if (h) begin m_mode = 2; m_valid = 0; m_insn = 0; end
      else if (!s) begin
        m_ipc = m_pc;
        m_ipc1 = (m_pc + 1) % 4096;
        m_insn = 32'hA000_0000 + 32'(m_pc);
        m_valid = 1;
        m_pc = (m_pc + 1) % 4096;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; stall = 0; redirect = 0; halt = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (obs() !== 70'({12'h000, 12'h000, 12'h000, 32'h0, 1'b0, 1'b0})) begin
      n_fail++; $display("FAIL reset_values: got %h want all-zero", obs());
    end
    step(0, 0, 0, 0);
    n_checks++;
    if (ifid_valid !== 1'b0 || imem_addr !== 12'h000) begin
      n_fail++; $display("FAIL boot_edge: valid=%b addr=%h want 0/000", ifid_valid, imem_addr);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0);
      n_checks++;
      if (obs() !== expv() || ifid_pc !== 12'(i) || ifid_insn !== 32'hA000_0000 + 32'(i) || !ifid_valid) begin
        n_fail++; $display("FAIL seq_fetch[%0d]: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_wrap();
    while (m_pc != 12'hFFE) begin
      step(0, 0, 0, 0);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL run_to_ffe: got %h want %h", obs(), expv());
      end
    end
    step(0, 0, 0, 0);
    n_checks++;
    if (ifid_pc !== 12'hFFE || ifid_pc_plus1 !== 12'hFFF) begin
      n_fail++; $display("FAIL fetch_ffe: pc=%h plus1=%h want FFE/FFF", ifid_pc, ifid_pc_plus1);
    end
    step(0, 0, 0, 0);
    n_checks++;
    if (ifid_pc !== 12'hFFF || ifid_pc_plus1 !== 12'h000 || imem_addr !== 12'h000) begin
      n_fail++; $display("FAIL wrap_fff: pc=%h plus1=%h addr=%h want FFF/000/000", ifid_pc, ifid_pc_plus1, imem_addr);
    end
  endtask

  task automatic test_stall();
    logic [69:0] frozen;
    step(0, 1, 12'h010, 0);
    frozen = obs();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      n_checks++;
      if (obs() !== frozen || imem_addr !== 12'h010 || obs() !== expv()) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got %h want %h", i, obs(), frozen);
      end
    end
    step(0, 0, 0, 0);
    n_checks++;
    if (ifid_pc !== 12'h010 || !ifid_valid || ifid_insn !== 32'hA000_0010) begin
      n_fail++; $display("FAIL stall_release: pc=%h valid=%b want 010/1", ifid_pc, ifid_valid);
    end
  endtask

  task automatic test_redirect();
    step(1, 1, 12'h3A0, 0);
    n_checks++;
    if (imem_addr !== 12'h3A0 || ifid_valid !== 1'b0 || ifid_insn !== 32'h0) begin
      n_fail++; $display("FAIL redirect_bubble: addr=%h valid=%b want 3A0/0", imem_addr, ifid_valid);
    end
    step(0, 0, 0, 0);
    n_checks++;
    if (ifid_pc !== 12'h3A0 || !ifid_valid || obs() !== expv()) begin
      n_fail++; $display("FAIL redirect_target: pc=%h valid=%b want 3A0/1", ifid_pc, ifid_valid);
    end
    step(0, 1, 12'h3A1, 0);
    step(0, 0, 0, 0);
    n_checks++;
    if (ifid_pc !== 12'h3A1 || !ifid_valid) begin
      n_fail++; $display("FAIL redirect_same_pc: pc=%h valid=%b want 3A1/1", ifid_pc, ifid_valid);
    end
  endtask

  task automatic test_halt();
    step(0, 1, 12'h020, 0);
    step(0, 0, 0, 1);
    n_checks++;
    if (halted !== 1'b1 || ifid_valid !== 1'b0 || imem_addr !== 12'h020) begin
      n_fail++; $display("FAIL halt_entry: halted=%b valid=%b addr=%h want 1/0/020", halted, ifid_valid, imem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 12'h777, 0);
      n_checks++;
      if (imem_addr !== 12'h020 || halted !== 1'b1 || obs() !== expv()) begin
        n_fail++; $display("FAIL halt_sticky[%0d]: addr=%h halted=%b want 020/1", i, imem_addr, halted);
      end
    end
    do_reset();
    n_checks++;
    if (halted !== 1'b0 || imem_addr !== 12'h000) begin
      n_fail++; $display("FAIL halt_reset: halted=%b addr=%h want 0/000", halted, imem_addr);
    end
    step(0, 0, 0, 1);
    n_checks++;
    if (halted !== 1'b0) begin
      n_fail++; $display("FAIL halt_in_boot: halted=%b want 0", halted);
    end
    step(0, 0, 0, 1);
    n_checks++;
    if (halted !== 1'b1) begin
      n_fail++; $display("FAIL halt_first_run: halted=%b want 1", halted);
    end
    do_reset();
    step(0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    step(0, 1, 12'h055, 0);
    step(0, 0, 0, 0);
    step(0, 1, 12'h055, 0);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 70'({12'h000, 12'h000, 12'h000, 32'h0, 1'b0, 1'b0})) begin
      n_fail++; $display("FAIL async_reset: got %h want all-zero", obs());
    end
    model_reset();
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (m_mode == 2 && $urandom_range(0, 7) == 0) do_reset();
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, 12'($urandom), $urandom_range(0, 49) == 0);
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL random[%0d]: got %h want %h", i, obs(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wrap();
    test_stall();
    test_redirect();
    test_halt();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
